// File: rtl/cellrv32_npu_address_sequencer.sv
// Command-driven address issuer for NPU buffer drains: one (base, length, stride) command in,
// LENGTH strided addresses out over a valid/ready handshake.
//   state  | meaning
//   IDLE   | waiting for a command, cmd_ready_o high
//   RUN    | issuing addresses, one per accepted beat
//   DONE   | burst finished normally, done_o pulses for this cycle
module cellrv32_npu_address_sequencer #(
  parameter int ADDRESS_WIDTH = 24,
  parameter int LENGTH_WIDTH  = 16,
  parameter int MATRIX_WIDTH  = 14
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [ADDRESS_WIDTH-1:0] cmd_base_i,
  input  logic [LENGTH_WIDTH-1:0]  cmd_length_i,
  input  logic [ADDRESS_WIDTH-1:0] cmd_stride_i,
  input  logic                     abort_i,
  output logic                     addr_valid_o,
  input  logic                     addr_ready_i,
  output logic [ADDRESS_WIDTH-1:0] addr_o,
  output logic [LENGTH_WIDTH-1:0]  addr_index_o,
  output logic                     addr_last_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH-1:0] r_stride;
  logic [LENGTH_WIDTH-1:0]  r_index;
  logic [LENGTH_WIDTH-1:0]  r_remaining;
  logic                     r_valid;
  logic                     r_last;
  logic                     r_busy;
  logic                     r_done;

  logic w_accept;
  logic w_beat;

  assign cmd_ready_o = (r_state == S_IDLE) & ~rst_i;
  assign w_accept    = cmd_valid_i & cmd_ready_o;
  assign w_beat      = r_valid & addr_ready_i;

  assign addr_valid_o = r_valid;
  assign addr_o       = r_addr;
  assign addr_index_o = r_index;
  assign addr_last_o  = r_last;
  assign busy_o       = r_busy;
  assign done_o       = r_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_stride    <= ADDRESS_WIDTH'(MATRIX_WIDTH);
      r_index     <= '0;
      r_remaining <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_busy   <= 1'b1;
            r_stride <= cmd_stride_i;
            if (cmd_length_i == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_RUN;
              r_valid     <= 1'b1;
              r_addr      <= cmd_base_i;
              r_index     <= '0;
              r_last      <= (cmd_length_i == LENGTH_WIDTH'(1));
              r_remaining <= cmd_length_i - LENGTH_WIDTH'(1);
            end
          end
        end
        S_RUN: begin
          // abort wins over a coincident beat; that beat is simply dropped here
          if (abort_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_beat) begin
            if (r_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_addr      <= r_addr + r_stride;
              r_index     <= r_index + LENGTH_WIDTH'(1);
              r_remaining <= r_remaining - LENGTH_WIDTH'(1);
              r_last      <= (r_remaining == LENGTH_WIDTH'(1));
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cellrv32_npu_address_sequencer.sv
// Directed bench for the NPU address sequencer: bursts, back-pressure, zero length,
// address wrap, abort and mid-burst reset.
module tb_cellrv32_npu_address_sequencer;

  localparam int AW = 24;
  localparam int LW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_base_i;
  logic [LW-1:0] cmd_length_i;
  logic [AW-1:0] cmd_stride_i;
  logic          abort_i;
  logic          addr_valid_o;
  logic          addr_ready_i;
  logic [AW-1:0] addr_o;
  logic [LW-1:0] addr_index_o;
  logic          addr_last_o;
  logic          busy_o;
  logic          done_o;

  int total = 0;
  int bad   = 0;

  cellrv32_npu_address_sequencer #(
    .ADDRESS_WIDTH(AW),
    .LENGTH_WIDTH (LW),
    .MATRIX_WIDTH (14)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_base_i  (cmd_base_i),
    .cmd_length_i(cmd_length_i),
    .cmd_stride_i(cmd_stride_i),
    .abort_i     (abort_i),
    .addr_valid_o(addr_valid_o),
    .addr_ready_i(addr_ready_i),
    .addr_o      (addr_o),
    .addr_index_o(addr_index_o),
    .addr_last_o (addr_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] idx,
                          input logic last);
    chk({tag, "_valid"}, 32'(addr_valid_o), 32'd1);
    chk({tag, "_addr"},  32'(addr_o),       32'(a));
    chk({tag, "_index"}, 32'(addr_index_o), 32'(idx));
    chk({tag, "_last"},  32'(addr_last_o),  32'(last));
    chk({tag, "_busy"},  32'(busy_o),       32'd1);
    chk({tag, "_done"},  32'(done_o),       32'd0);
  endtask

  logic [AW-1:0] t1_addr [4] = '{24'h000100, 24'h00010E, 24'h00011C, 24'h00012A};
  logic [AW-1:0] t2_addr [6] = '{24'h10, 24'h11, 24'h11, 24'h11, 24'h12, 24'h12};
  logic [LW-1:0] t2_idx  [6] = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2};
  logic          t2_rdy  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [AW-1:0] t4_addr [4] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_base_i = '0; cmd_length_i = '0;
    cmd_stride_i = '0; abort_i = 1'b0; addr_ready_i = 1'b0;

    // reset
    tick(); tick();
    chk("rst_valid", 32'(addr_valid_o), 32'd0);
    chk("rst_addr",  32'(addr_o),       32'd0);
    chk("rst_index", 32'(addr_index_o), 32'd0);
    chk("rst_last",  32'(addr_last_o),  32'd0);
    chk("rst_busy",  32'(busy_o),       32'd0);
    chk("rst_done",  32'(done_o),       32'd0);
    chk("rst_ready", 32'(cmd_ready_o),  32'd0);
    rst_i = 1'b0;
    #1;
    chk("rel_ready", 32'(cmd_ready_o), 32'd1);

    // 1: stride-14 burst at full throughput
    cmd_valid_i = 1'b1; cmd_base_i = 24'h000100; cmd_length_i = 16'd4; cmd_stride_i = 24'd14;
    addr_ready_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_beat("t1", t1_addr[i], LW'(i), i == 3);
      chk("t1_cmdrdy", 32'(cmd_ready_o), 32'd0);
      tick();
    end
    chk("t1_end_valid", 32'(addr_valid_o), 32'd0);
    chk("t1_end_done",  32'(done_o),       32'd1);
    chk("t1_end_busy",  32'(busy_o),       32'd1);
    chk("t1_end_cmdrdy", 32'(cmd_ready_o), 32'd0);
    tick();
    chk("t1_idle_done", 32'(done_o),      32'd0);
    chk("t1_idle_busy", 32'(busy_o),      32'd0);
    chk("t1_idle_rdy",  32'(cmd_ready_o), 32'd1);

    // 2: back-pressure holds the presented address
    cmd_valid_i = 1'b1; cmd_base_i = 24'h10; cmd_length_i = 16'd3; cmd_stride_i = 24'd1;
    tick();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      addr_ready_i = t2_rdy[i];
      chk_beat("t2", t2_addr[i], t2_idx[i], i >= 4);
      tick();
    end
    chk("t2_end_valid", 32'(addr_valid_o), 32'd0);
    chk("t2_end_done",  32'(done_o),       32'd1);
    addr_ready_i = 1'b1;
    tick();
    chk("t2_idle_done", 32'(done_o), 32'd0);

    // 3: zero-length command
    cmd_valid_i = 1'b1; cmd_base_i = 24'h55; cmd_length_i = 16'd0; cmd_stride_i = 24'd3;
    tick();
    cmd_valid_i = 1'b0;
    chk("t3_valid",  32'(addr_valid_o), 32'd0);
    chk("t3_done",   32'(done_o),       32'd1);
    chk("t3_busy",   32'(busy_o),       32'd1);
    chk("t3_cmdrdy", 32'(cmd_ready_o),  32'd0);
    tick();
    chk("t3_idle_valid", 32'(addr_valid_o), 32'd0);
    chk("t3_idle_done",  32'(done_o),       32'd0);
    chk("t3_idle_rdy",   32'(cmd_ready_o),  32'd1);

    // 4: address wraps silently at 2**24
    cmd_valid_i = 1'b1; cmd_base_i = 24'hFFFFFE; cmd_length_i = 16'd4; cmd_stride_i = 24'd1;
    tick();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_beat("t4", t4_addr[i], LW'(i), i == 3);
      tick();
    end
    chk("t4_end_done", 32'(done_o), 32'd1);
    tick();

    // 5: abort after the second beat, then a clean restart
    cmd_valid_i = 1'b1; cmd_base_i = 24'h200; cmd_length_i = 16'd8; cmd_stride_i = 24'd1;
    tick();
    cmd_valid_i = 1'b0;
    chk_beat("t5_b0", 24'h200, 16'd0, 1'b0);
    tick();
    chk_beat("t5_b1", 24'h201, 16'd1, 1'b0);
    tick();
    chk_beat("t5_b2", 24'h202, 16'd2, 1'b0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("t5_ab_valid",  32'(addr_valid_o), 32'd0);
    chk("t5_ab_last",   32'(addr_last_o),  32'd0);
    chk("t5_ab_done",   32'(done_o),       32'd0);
    chk("t5_ab_busy",   32'(busy_o),       32'd0);
    chk("t5_ab_cmdrdy", 32'(cmd_ready_o),  32'd1);
    cmd_valid_i = 1'b1; cmd_base_i = 24'h300; cmd_length_i = 16'd2; cmd_stride_i = 24'd4;
    tick();
    cmd_valid_i = 1'b0;
    chk("t5_noabdone", 32'(done_o), 32'd0);
    chk_beat("t5_r0", 24'h300, 16'd0, 1'b0);
    tick();
    chk_beat("t5_r1", 24'h304, 16'd1, 1'b1);
    tick();
    chk("t5_r_done", 32'(done_o), 32'd1);
    tick();

    // 6: reset mid-burst, then a command held through DONE
    cmd_valid_i = 1'b1; cmd_base_i = 24'h400; cmd_length_i = 16'd8; cmd_stride_i = 24'd2;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    tick();
    chk_beat("t6_b2", 24'h404, 16'd2, 1'b0);
    rst_i = 1'b1;
    tick();
    chk("t6_rst_valid", 32'(addr_valid_o), 32'd0);
    chk("t6_rst_addr",  32'(addr_o),       32'd0);
    chk("t6_rst_index", 32'(addr_index_o), 32'd0);
    chk("t6_rst_busy",  32'(busy_o),       32'd0);
    chk("t6_rst_done",  32'(done_o),       32'd0);
    chk("t6_rst_rdy",   32'(cmd_ready_o),  32'd0);
    rst_i = 1'b0;
    #1;
    chk("t6_rel_rdy", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1; cmd_base_i = 24'h0; cmd_length_i = 16'd0; cmd_stride_i = 24'd0;
    tick();
    chk("t6_done_pulse", 32'(done_o),      32'd1);
    chk("t6_done_rdy",   32'(cmd_ready_o), 32'd0);
    cmd_base_i = 24'h500; cmd_length_i = 16'd1; cmd_stride_i = 24'd7;
    tick();
    chk("t6_idle_valid", 32'(addr_valid_o), 32'd0);
    chk("t6_idle_done",  32'(done_o),       32'd0);
    chk("t6_idle_rdy",   32'(cmd_ready_o),  32'd1);
    tick();
    cmd_valid_i = 1'b0;
    chk_beat("t6_held", 24'h500, 16'd0, 1'b1);
    tick();
    chk("t6_held_done", 32'(done_o), 32'd1);
    tick();
    chk("t6_final_busy", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
